// File: rtl/register_bank_pkg.sv
// register_bank shared definitions
// widths, register-zero constant and dump FSM encoding
package register_bank_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;
    localparam logic [ADDR_W-1:0] REG_LAST = ADDR_W'(NREGS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } dump_state_e;

endpackage

// File: rtl/register_bank_if.sv
// register_bank port bundle
// write-back, decode read ports and debug dump handshake
interface register_bank_if;
    import register_bank_pkg::*;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr_a;
    logic [ADDR_W-1:0] raddr_b;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic              dump_start;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_idx;
    logic [DATA_W-1:0] dump_data;
    logic              dump_busy;
    logic              dump_done;

    modport slave (
        input  we, waddr, wdata,
        input  raddr_a, raddr_b,
        output rdata_a, rdata_b,
        input  dump_start, dump_ready,
        output dump_valid, dump_idx,
        output dump_data, dump_busy, dump_done
    );

    modport master (
        output we, waddr, wdata,
        output raddr_a, raddr_b,
        input  rdata_a, rdata_b,
        output dump_start, dump_ready,
        input  dump_valid, dump_idx,
        input  dump_data, dump_busy, dump_done
    );

endinterface

// File: rtl/register_bank_dump_fsm.sv
// regbank_dump_fsm: sequencing of the debug register dump
// owns state, index and handshake outputs; strobes data capture
module regbank_dump_fsm
    import register_bank_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ready,
    output logic              valid,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] idx,
    output logic              cap,
    output logic [ADDR_W-1:0] cap_idx
);

    dump_state_e state;

    // capture on dump start (index 0) or on each non-final transfer
    always_comb begin
        cap     = 1'b0;
        cap_idx = REG_ZERO;
        if (state == IDLE && start) begin
            cap = 1'b1;
        end else if (state == SEND && ready && idx != REG_LAST) begin
            cap     = 1'b1;
            cap_idx = idx + 1'b1;
        end
    end

    // dump state machine with registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= REG_ZERO;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= SEND;
                        idx   <= REG_ZERO;
                        valid <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                SEND: begin
                    if (ready) begin
                        if (idx == REG_LAST) begin
                            state <= DONE;
                            valid <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/register_bank.sv
// register_bank: MIPS GPR file with write bypass and debug dump
// r0 reads as zero; dump words are captured with the same bypass
module register_bank
    import register_bank_pkg::*;
(
    input logic             clk,
    input logic             rst,
    register_bank_if.slave  bus
);

    logic [DATA_W-1:0] regs [NREGS];
    logic              cap;
    logic [ADDR_W-1:0] cap_idx;

    function automatic logic [DATA_W-1:0] bypass(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] stored,
        input logic              w,
        input logic [ADDR_W-1:0] wa,
        input logic [DATA_W-1:0] wd
    );
        if (a == REG_ZERO) return '0;
        if (w && wa == a) return wd;
        return stored;
    endfunction

    assign bus.rdata_a = bypass(bus.raddr_a, regs[bus.raddr_a],
                                bus.we, bus.waddr, bus.wdata);
    assign bus.rdata_b = bypass(bus.raddr_b, regs[bus.raddr_b],
                                bus.we, bus.waddr, bus.wdata);

    // write-back port; writes to r0 are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (bus.we && bus.waddr != REG_ZERO) begin
            regs[bus.waddr] <= bus.wdata;
        end
    end

    // dump word capture, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.dump_data <= '0;
        end else if (cap) begin
            bus.dump_data <= bypass(cap_idx, regs[cap_idx],
                                    bus.we, bus.waddr, bus.wdata);
        end
    end

    regbank_dump_fsm u_fsm (
        .clk     (clk),
        .rst     (rst),
        .start   (bus.dump_start),
        .ready   (bus.dump_ready),
        .valid   (bus.dump_valid),
        .busy    (bus.dump_busy),
        .done    (bus.dump_done),
        .idx     (bus.dump_idx),
        .cap     (cap),
        .cap_idx (cap_idx)
    );

endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: directed bench with a per-cycle reference model
// model tracks register contents and the expected dump word stream
module tb_register_bank;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_en = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    register_bank_if bus();

    register_bank dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mreg [32];
    bit          mbusy = 1'b0;
    bit          mdone = 1'b0;
    int          midx  = 0;
    logic [31:0] mdata = '0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (bus.we === 1'b1 && bus.waddr == a) return bus.wdata;
        return mreg[a];
    endfunction

    // advance the model by one clock edge using the inputs seen there
    task automatic model_step();
        bit nd;
        if (rst) begin
            for (int i = 0; i < 32; i++) mreg[i] = '0;
            mbusy = 1'b0;
            mdone = 1'b0;
            midx  = 0;
            mdata = '0;
        end else begin
            nd = 1'b0;
            if (mbusy) begin
                if (bus.dump_ready) begin
                    if (midx == 31) begin
                        mbusy = 1'b0;
                        nd    = 1'b1;
                    end else begin
                        midx  = midx + 1;
                        mdata = exp_rd(5'(midx));
                    end
                end
            end else if (!mdone && bus.dump_start) begin
                mbusy = 1'b1;
                midx  = 0;
                mdata = exp_rd(5'd0);
            end
            mdone = nd;
            if (bus.we && bus.waddr != 5'd0)
                mreg[bus.waddr] = bus.wdata;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("rdata_a", bus.rdata_a, exp_rd(bus.raddr_a));
            check("rdata_b", bus.rdata_b, exp_rd(bus.raddr_b));
            check("dump_valid", {31'b0, bus.dump_valid}, {31'b0, mbusy});
            check("dump_busy", {31'b0, bus.dump_busy}, {31'b0, mbusy});
            check("dump_done", {31'b0, bus.dump_done}, {31'b0, mdone});
            if (mbusy) begin
                check("dump_idx", {27'b0, bus.dump_idx}, 32'(midx));
                check("dump_data", bus.dump_data, mdata);
            end
        end
    end

    task automatic wait_done(input string name);
        int guard;
        guard = 0;
        while (bus.dump_done !== 1'b1 && guard < 100) begin
            tick();
            guard++;
        end
        nvec++;
        if (guard >= 100) begin
            nerr++;
            $display("FAIL %s: got timeout want dump_done", name);
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        bus.we = 1'b0;
        bus.waddr = '0;
        bus.wdata = '0;
        bus.raddr_a = '0;
        bus.raddr_b = '0;
        bus.dump_start = 1'b0;
        bus.dump_ready = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;

        // 1: all registers read zero after reset
        for (int a = 0; a < 32; a++) begin
            bus.raddr_a = 5'(a);
            bus.raddr_b = 5'(31 - a);
            @(negedge clk);
            if (a == 17) check("rst_rd_a17", bus.rdata_a, 32'h0);
            tick();
        end
        @(negedge clk);
        check("rst_valid", {31'b0, bus.dump_valid}, 32'h0);
        check("rst_busy", {31'b0, bus.dump_busy}, 32'h0);

        // 2: plain write and r0 discard
        tick();
        bus.we = 1'b1;
        bus.waddr = 5'd5;
        bus.wdata = 32'hDEADBEEF;
        tick();
        bus.we = 1'b0;
        bus.raddr_a = 5'd5;
        @(negedge clk);
        check("wr_r5", bus.rdata_a, 32'hDEADBEEF);
        tick();
        bus.we = 1'b1;
        bus.waddr = 5'd0;
        bus.wdata = 32'h1234;
        bus.raddr_a = 5'd0;
        @(negedge clk);
        check("r0_bypass", bus.rdata_a, 32'h0);
        tick();
        bus.we = 1'b0;
        @(negedge clk);
        check("r0_after", bus.rdata_a, 32'h0);

        // 3: same-cycle bypass on both ports
        tick();
        bus.we = 1'b1;
        bus.waddr = 5'd7;
        bus.wdata = 32'hA5A5A5A5;
        bus.raddr_a = 5'd7;
        bus.raddr_b = 5'd7;
        @(negedge clk);
        check("byp_a", bus.rdata_a, 32'hA5A5A5A5);
        check("byp_b", bus.rdata_b, 32'hA5A5A5A5);
        tick();
        bus.we = 1'b0;

        // 4: preload and full-speed dump
        for (int n = 1; n < 32; n++) begin
            bus.we = 1'b1;
            bus.waddr = 5'(n);
            bus.wdata = 32'(n * 16);
            tick();
        end
        bus.we = 1'b0;
        bus.dump_ready = 1'b1;
        bus.dump_start = 1'b1;
        tick();
        bus.dump_start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (k == 0 || k == 9 || k == 31) begin
                check("dmp_idx", {27'b0, bus.dump_idx}, 32'(k));
                check("dmp_data", bus.dump_data, 32'(k * 16));
            end
            tick();
        end
        @(negedge clk);
        check("dmp_done", {31'b0, bus.dump_done}, 32'h1);
        check("dmp_vld_off", {31'b0, bus.dump_valid}, 32'h0);
        tick();
        @(negedge clk);
        check("dmp_done_off", {31'b0, bus.dump_done}, 32'h0);

        // 5: stall at idx 4 with a write to r4
        bus.dump_start = 1'b1;
        tick();
        bus.dump_start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        bus.dump_ready = 1'b0;
        bus.we = 1'b1;
        bus.waddr = 5'd4;
        bus.wdata = 32'h0000FFFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_idx", {27'b0, bus.dump_idx}, 32'h4);
            check("stall_data", bus.dump_data, 32'h40);
            tick();
            bus.we = 1'b0;
        end
        bus.dump_ready = 1'b1;
        @(negedge clk);
        check("sent_word", bus.dump_data, 32'h40);
        wait_done("dump5_done");

        // 6: reset mid-dump, with a write in the reset cycle
        bus.dump_start = 1'b1;
        tick();
        bus.dump_start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        @(negedge clk);
        check("pre_rst_idx", {27'b0, bus.dump_idx}, 32'd10);
        tick();
        rst = 1'b1;
        bus.we = 1'b1;
        bus.waddr = 5'd3;
        bus.wdata = 32'h77;
        tick();
        rst = 1'b0;
        bus.we = 1'b0;
        bus.raddr_a = 5'd3;
        @(negedge clk);
        check("rst_valid2", {31'b0, bus.dump_valid}, 32'h0);
        check("rst_busy2", {31'b0, bus.dump_busy}, 32'h0);
        check("rst_idx2", {27'b0, bus.dump_idx}, 32'h0);
        check("rst_no_wr", bus.rdata_a, 32'h0);
        tick();
        bus.dump_start = 1'b1;
        tick();
        bus.dump_start = 1'b0;
        @(negedge clk);
        check("restart_idx", {27'b0, bus.dump_idx}, 32'h0);
        check("restart_vld", {31'b0, bus.dump_valid}, 32'h1);
        wait_done("dump6_done");

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
